// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with 4-byte blocks.
// It serves hits with no stall and runs write-back and refill transfers on a miss.
module dcache_controller #(
    parameter int INDEX_W = 3,
    parameter int ADDR_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [7:0]        WRITEDATA,
    output logic [7:0]        READDATA,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-3:0] MEM_ADDRESS,
    output logic [31:0]       MEM_WRITEDATA,
    input  logic [31:0]       MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int NBLK  = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t            state;
    logic [31:0]       data_arr [NBLK];
    logic [TAG_W-1:0]  tag_arr  [NBLK];
    logic [NBLK-1:0]   valid;
    logic [NBLK-1:0]   dirty;

    logic [TAG_W-1:0]   tag_in;
    logic [INDEX_W-1:0] index;
    logic [1:0]         offset;
    logic               req;
    logic               store;
    logic               hit;

    assign tag_in = ADDRESS[ADDR_W-1:INDEX_W+2];
    assign index  = ADDRESS[INDEX_W+1:2];
    assign offset = ADDRESS[1:0];
    assign req    = READ | WRITE;
    // When READ and WRITE are both high, the access is a load and nothing is stored.
    assign store  = WRITE & ~READ;
    assign hit    = valid[index] && (tag_arr[index] == tag_in);

    assign READDATA      = data_arr[index][{offset, 3'b000} +: 8];
    assign BUSYWAIT      = ~RESET & req & ~((state == IDLE) & hit);
    assign MEM_READ      = (state == ALLOCATE);
    assign MEM_WRITE     = (state == WRITEBACK);
    // A write-back targets the victim's stored tag. A refill targets the requested tag.
    assign MEM_ADDRESS   = MEM_WRITE ? {tag_arr[index], index} : {tag_in, index};
    assign MEM_WRITEDATA = data_arr[index];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (store) begin
                                data_arr[index][{offset, 3'b000} +: 8] <= WRITEDATA;
                                dirty[index] <= 1'b1;
                            end
                        end else if (valid[index] && dirty[index]) begin
                            state <= WRITEBACK;
                        end else begin
                            state <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (!MEM_BUSYWAIT) begin
                        data_arr[index] <= MEM_READDATA;
                        tag_arr[index]  <= tag_in;
                        valid[index]    <= 1'b1;
                        dirty[index]    <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a multi-cycle memory responder and an
// architectural cache/memory reference model that predicts stalls, strobes and data.
module tb_dcache_controller;
    logic        CLK = 1'b0;
    logic        RESET, READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;

    dcache_controller #(.INDEX_W(3), .ADDR_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory responder: holds the strobe busy for mem_lat cycles in total.
    int          mem_lat = 3;
    int          cnt = 0;
    logic [31:0] init_mem [64];
    logic [31:0] wb_mem   [64];
    logic [63:0] wb_vld = '0;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < mem_lat - 1);
    assign MEM_READDATA = wb_vld[MEM_ADDRESS] ? wb_mem[MEM_ADDRESS] : init_mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (RESET) cnt <= 0;
        else if (MEM_READ || MEM_WRITE) begin
            if (MEM_BUSYWAIT) cnt <= cnt + 1;
            else begin
                cnt <= 0;
                if (MEM_WRITE) begin
                    wb_mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                    wb_vld[MEM_ADDRESS] <= 1'b1;
                end
            end
        end else cnt <= 0;
    end

    // Reference model: architectural cache contents and the expected memory image.
    logic [31:0] rmem [64];
    logic [31:0] rdat [8];
    logic [2:0]  rtag [8];
    bit          rv [8];
    bit          rdirty [8];

    typedef struct {
        int          stalls, nrd, nwr;
        logic [7:0]  rdata;
        logic [5:0]  wb_addr, rf_addr;
        logic [31:0] wb_data;
        bit          both, wr_first, tmo;
    } obs_t;

    int checks = 0;
    int errors = 0;

    task automatic clear_obs(output obs_t o);
        o.stalls = 0; o.nrd = 0; o.nwr = 0; o.rdata = '0; o.wb_addr = '0;
        o.rf_addr = '0; o.wb_data = '0; o.both = 0; o.wr_first = 0; o.tmo = 0;
    endtask

    // Expected outcome of one access, derived from the cache rules.
    task automatic model(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d,
                         output obs_t e);
        logic [2:0] idx, t;
        int off;
        idx = a[4:2]; t = a[7:5]; off = int'(a[1:0]);
        clear_obs(e);
        if (!(rv[idx] && rtag[idx] == t)) begin
            if (rv[idx] && rdirty[idx]) begin
                e.nwr = mem_lat; e.wr_first = 1;
                e.wb_addr = {rtag[idx], idx}; e.wb_data = rdat[idx];
                rmem[{rtag[idx], idx}] = rdat[idx];
            end
            e.nrd = mem_lat; e.rf_addr = {t, idx};
            rdat[idx] = rmem[{t, idx}]; rtag[idx] = t; rv[idx] = 1; rdirty[idx] = 0;
            e.stalls = e.nwr + e.nrd + 1;
        end
        e.rdata = rdat[idx][off*8 +: 8];
        if (w && !r) begin
            rdat[idx][off*8 +: 8] = d;
            rdirty[idx] = 1;
        end
    endtask

    // Drives one request, called just after a posedge, and observes at negedges until the stall clears.
    task automatic access(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d,
                          output obs_t o);
        bit done, seen;
        done = 0; seen = 0;
        clear_obs(o);
        READ = r; WRITE = w; ADDRESS = a; WRITEDATA = d;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge CLK);
            if (MEM_READ && MEM_WRITE) o.both = 1;
            if (MEM_WRITE) begin
                if (!seen) o.wr_first = 1;
                o.nwr++; o.wb_addr = MEM_ADDRESS; o.wb_data = MEM_WRITEDATA;
            end
            if (MEM_READ) begin o.nrd++; o.rf_addr = MEM_ADDRESS; end
            if (MEM_READ || MEM_WRITE) seen = 1;
            if (!BUSYWAIT) begin o.rdata = READDATA; done = 1; end
            else o.stalls++;
        end
        if (!done) o.tmo = 1;
        @(posedge CLK); #1;
        READ = 0; WRITE = 0;
    endtask

    task automatic test_reset;
        RESET = 1; READ = 1; WRITE = 0; ADDRESS = 8'h25; WRITEDATA = 0;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL rst_busywait: got %b expected 0", BUSYWAIT); end
        checks++;
        if ({MEM_READ, MEM_WRITE} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b expected 00", {MEM_READ, MEM_WRITE}); end
        @(posedge CLK); #1;
        RESET = 0; READ = 0;
        for (int i = 0; i < 8; i++) begin rv[i] = 0; rdirty[i] = 0; end
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin errors++; $display("FAIL rst_idle: got busy=%b rd=%b expected 0 0", BUSYWAIT, MEM_READ); end
        @(posedge CLK); #1;
    endtask

    task automatic test_clean_miss;
        obs_t o, e;
        mem_lat = 3;
        model(1, 0, 8'h25, 8'h00, e);
        access(1, 0, 8'h25, 8'h00, o);
        checks++; if (o.tmo) begin errors++; $display("FAIL miss_timeout: got timeout expected done"); end
        checks++; if (o.stalls !== 4 || o.stalls !== e.stalls) begin errors++; $display("FAIL miss_stalls: got %0d expected 4", o.stalls); end
        checks++; if (o.nrd !== 3 || o.nwr !== 0) begin errors++; $display("FAIL miss_strobes: got rd=%0d wr=%0d expected rd=3 wr=0", o.nrd, o.nwr); end
        checks++; if (o.rf_addr !== 6'h09) begin errors++; $display("FAIL miss_addr: got %h expected 09", o.rf_addr); end
        checks++; if (o.rdata !== 8'hBB) begin errors++; $display("FAIL miss_rdata: got %h expected bb", o.rdata); end
    endtask

    task automatic test_read_hit;
        obs_t o, e;
        model(1, 0, 8'h27, 8'h00, e);
        access(1, 0, 8'h27, 8'h00, o);
        checks++; if (o.stalls !== 0 || o.nrd !== 0 || o.nwr !== 0) begin errors++; $display("FAIL hit_nostall: got stalls=%0d rd=%0d wr=%0d expected 0 0 0", o.stalls, o.nrd, o.nwr); end
        checks++; if (o.rdata !== 8'hDD || o.rdata !== e.rdata) begin errors++; $display("FAIL hit_rdata: got %h expected dd", o.rdata); end
    endtask

    task automatic test_write_hit;
        obs_t o, e;
        model(0, 1, 8'h25, 8'h5A, e);
        access(0, 1, 8'h25, 8'h5A, o);
        checks++; if (o.stalls !== 0 || o.nwr !== 0 || o.nrd !== 0) begin errors++; $display("FAIL whit_nostall: got stalls=%0d wr=%0d rd=%0d expected 0 0 0", o.stalls, o.nwr, o.nrd); end
        model(1, 0, 8'h25, 8'h00, e);
        access(1, 0, 8'h25, 8'h00, o);
        checks++; if (o.rdata !== 8'h5A || o.stalls !== 0) begin errors++; $display("FAIL whit_readback: got %h stalls=%0d expected 5a stalls=0", o.rdata, o.stalls); end
    endtask

    task automatic test_dirty_miss;
        obs_t o, e;
        model(1, 0, 8'hE5, 8'h00, e);
        access(1, 0, 8'hE5, 8'h00, o);
        checks++; if (!o.wr_first || o.nwr !== 3 || o.wb_addr !== 6'h09) begin errors++; $display("FAIL dmiss_wb: got first=%b n=%0d addr=%h expected 1 3 09", o.wr_first, o.nwr, o.wb_addr); end
        checks++; if (o.wb_data !== 32'hDDCC5AAA) begin errors++; $display("FAIL dmiss_wbdata: got %h expected ddcc5aaa", o.wb_data); end
        checks++; if (o.nrd !== 3 || o.rf_addr !== 6'h39) begin errors++; $display("FAIL dmiss_refill: got n=%0d addr=%h expected 3 39", o.nrd, o.rf_addr); end
        checks++; if (o.stalls !== 7 || o.rdata !== e.rdata || o.both) begin errors++; $display("FAIL dmiss_result: got stalls=%0d data=%h both=%b expected 7 %h 0", o.stalls, o.rdata, o.both, e.rdata); end
    endtask

    task automatic test_reset_mid_alloc;
        obs_t o, e;
        bit seen_rd;
        seen_rd = 0;
        READ = 1; WRITE = 0; ADDRESS = 8'h25;
        for (int c = 0; c < 20 && !seen_rd; c++) begin
            @(negedge CLK);
            if (MEM_READ) seen_rd = 1;
        end
        checks++; if (!seen_rd) begin errors++; $display("FAIL rmid_alloc: got no MEM_READ expected MEM_READ"); end
        RESET = 1;
        @(posedge CLK); #1;
        checks++; if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin errors++; $display("FAIL rmid_drop: got rd=%b busy=%b expected 0 0", MEM_READ, BUSYWAIT); end
        RESET = 0; READ = 0;
        for (int i = 0; i < 8; i++) begin rv[i] = 0; rdirty[i] = 0; end
        @(posedge CLK); #1;
        model(1, 0, 8'h25, 8'h00, e);
        access(1, 0, 8'h25, 8'h00, o);
        checks++; if (o.stalls !== 4 || o.nrd !== 3 || o.nwr !== 0) begin errors++; $display("FAIL rmid_refill: got stalls=%0d rd=%0d wr=%0d expected 4 3 0", o.stalls, o.nrd, o.nwr); end
        checks++; if (o.rdata !== 8'h5A || o.rdata !== e.rdata) begin errors++; $display("FAIL rmid_rdata: got %h expected 5a", o.rdata); end
    endtask

    task automatic test_read_write_both;
        obs_t o, e;
        model(1, 1, 8'h27, 8'h11, e);
        access(1, 1, 8'h27, 8'h11, o);
        checks++; if (o.stalls !== 0 || o.rdata !== 8'hDD) begin errors++; $display("FAIL rw_hit: got stalls=%0d data=%h expected 0 dd", o.stalls, o.rdata); end
        model(1, 0, 8'h27, 8'h00, e);
        access(1, 0, 8'h27, 8'h00, o);
        checks++; if (o.rdata !== 8'hDD) begin errors++; $display("FAIL rw_unchanged: got %h expected dd", o.rdata); end
        // Block must still be clean, so this miss refills with no write-back in a 1-cycle transfer.
        mem_lat = 1;
        model(1, 0, 8'hE7, 8'h00, e);
        access(1, 0, 8'hE7, 8'h00, o);
        checks++; if (o.nwr !== 0 || o.nrd !== 1 || o.stalls !== 2) begin errors++; $display("FAIL rw_clean_1cyc: got wr=%0d rd=%0d stalls=%0d expected 0 1 2", o.nwr, o.nrd, o.stalls); end
        checks++; if (o.rdata !== e.rdata || o.tmo) begin errors++; $display("FAIL rw_1cyc_data: got %h tmo=%b expected %h", o.rdata, o.tmo, e.rdata); end
    endtask

    task automatic test_random;
        obs_t o, e;
        bit r, w;
        logic [7:0] a, d;
        for (int n = 0; n < 80; n++) begin
            mem_lat = int'($urandom_range(1, 4));
            r = 1'($urandom); w = 1'($urandom);
            if (!r && !w) r = 1;
            a = {2'($urandom), 1'b0, 3'($urandom), 2'($urandom)} | {2'b00, 1'($urandom), 5'b0};
            d = 8'($urandom);
            model(r, w, a, d, e);
            access(r, w, a, d, o);
            checks++;
            if (o.tmo || o.both || o.stalls !== e.stalls || o.nrd !== e.nrd || o.nwr !== e.nwr) begin
                errors++;
                $display("FAIL rnd_timing[%0d] a=%h: got stalls=%0d rd=%0d wr=%0d both=%b tmo=%b expected %0d %0d %0d 0 0",
                         n, a, o.stalls, o.nrd, o.nwr, o.both, o.tmo, e.stalls, e.nrd, e.nwr);
            end
            checks++;
            if ((e.nwr != 0 && (o.wb_addr !== e.wb_addr || o.wb_data !== e.wb_data || !o.wr_first)) ||
                (e.nrd != 0 && o.rf_addr !== e.rf_addr)) begin
                errors++;
                $display("FAIL rnd_mem[%0d]: got wb=%h/%h rf=%h expected wb=%h/%h rf=%h",
                         n, o.wb_addr, o.wb_data, o.rf_addr, e.wb_addr, e.wb_data, e.rf_addr);
            end
            if (r) begin
                checks++;
                if (o.rdata !== e.rdata) begin errors++; $display("FAIL rnd_rdata[%0d] a=%h: got %h expected %h", n, a, o.rdata, e.rdata); end
            end
        end
    endtask

    task automatic test_mem_image;
        int bad;
        logic [31:0] eff;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            eff = wb_vld[i] ? wb_mem[i] : init_mem[i];
            if (eff !== rmem[i]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mem_image: got %0d differing blocks expected 0", bad); end
    endtask

    initial begin
        RESET = 1; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[6'h09] = 32'hDDCCBBAA;
        for (int i = 0; i < 64; i++) rmem[i] = init_mem[i];
        test_reset;
        test_clean_miss;
        test_read_hit;
        test_write_hit;
        test_dirty_miss;
        test_reset_mid_alloc;
        test_read_write_both;
        test_random;
        test_mem_image;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller. Sits between the CPU load/store path (lwd/swd, ALU result as address, reg-file port as store data) and the multi-cycle data memory.
- Serves hits with no stall.
- Sequences write-back and refill transfers on misses, stalling the CPU through BUSYWAIT.
- Block size is fixed at 4 bytes; the controller holds data, tag, valid and dirty arrays.

Parameters:
INDEX_W, 3, index bits; number of blocks = 2**INDEX_W
ADDR_W, 8, CPU byte-address width; TAG_W = ADDR_W - INDEX_W - 2 (default 3)

Ports:
CLK  input  1  clock, all state updates on posedge
RESET  input  1  synchronous, active-high
READ  input  1  CPU load request, held until BUSYWAIT low at a posedge
WRITE  input  1  CPU store request, held likewise
ADDRESS  input  ADDR_W  byte address: tag=[ADDR_W-1:INDEX_W+2], index=[INDEX_W+1:2], offset=[1:0]
WRITEDATA  input  8  store byte
READDATA  output  8  load byte, combinational
BUSYWAIT  output  1  CPU stall, combinational
MEM_READ  output  1  memory refill strobe
MEM_WRITE  output  1  memory write-back strobe
MEM_ADDRESS  output  ADDR_W-2  memory block address {tag,index}
MEM_WRITEDATA  output  32  block being written back
MEM_READDATA  input  32  refill block
MEM_BUSYWAIT  input  1  memory busy; high in the same cycle a strobe rises, low in the final cycle of the transfer

Behaviour:
- Reset (posedge with RESET=1): state<=IDLE; all valid and dirty bits cleared. Data and tag arrays are not cleared. MEM_READ=MEM_WRITE=0. BUSYWAIT forced 0 while RESET is high. Reset overrides any in-flight transfer; strobes drop after that edge.
- Request: req = READ|WRITE. READ&WRITE together is treated as READ with no store.
- Hit: valid[index] && tag[index]==ADDRESS tag.
- Byte lanes: offset 0 = bits[7:0] ... offset 3 = bits[31:24].
- READDATA = data[index] byte[offset], meaningful only on a hit in IDLE.
- BUSYWAIT = req && !(state==IDLE && hit).
- States:
  - IDLE: strobes low.
    - Read hit: no state change; CPU captures READDATA at the posedge.
    - Write hit: at the posedge, byte[offset] <= WRITEDATA and dirty<=1.
    - Miss with valid&&dirty: -> WRITEBACK.
    - Miss otherwise: -> ALLOCATE.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=data[index]. At a posedge with MEM_BUSYWAIT==0: -> ALLOCATE.
  - ALLOCATE: MEM_READ=1, MEM_ADDRESS={ADDRESS tag,index}. At a posedge with MEM_BUSYWAIT==0: data[index]<=MEM_READDATA, tag<=ADDRESS tag, valid<=1, dirty<=0, -> IDLE.
- After refill, IDLE sees a hit next cycle; a store is applied then. Store data is never merged during refill.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: N_alloc + 1 stall cycles, where N is the cycles the strobe is high.
  - Dirty miss: N_wb + N_alloc + 1.
- MEM_READ and MEM_WRITE are decoded from registered state only, never both high.
- Request dropped during WRITEBACK or ALLOCATE: the current transfer still completes and the refill is still installed. Return to IDLE.
- ADDRESS must be stable while BUSYWAIT is high. The controller samples tag/index combinationally and does not latch them.
- MEM_BUSYWAIT low in the first strobe cycle is legal: the transfer completes in 1 cycle.

Test Plan:
1. Reset, then READ ADDRESS=8'h25, memory block 6'h09 = 32'hDDCCBBAA, 3-cycle memory -> BUSYWAIT high 4 cycles, MEM_READ high 3 cycles with MEM_ADDRESS=6'h09, then READDATA=8'hBB with BUSYWAIT low.
2. Following READ 8'h27 -> hit, BUSYWAIT never high, READDATA=8'hDD, no memory strobes.
3. WRITE 8'h25 data 8'h5A (hit) -> 0 stalls; a subsequent READ 8'h25 returns 8'h5A; no MEM_WRITE issued.
4. READ 8'hE5 (same index 1, tag 3'b111, block dirty) -> MEM_WRITE first with MEM_ADDRESS=6'h09 and MEM_WRITEDATA=32'hDDCC5AAA, then MEM_READ with MEM_ADDRESS=6'h39, then hit; total stall = N_wb + N_alloc + 1.
5. Assert RESET during ALLOCATE -> after that edge MEM_READ=0, BUSYWAIT=0, state IDLE; re-READ 8'h25 -> miss (valid cleared) with a full refill.
6. READ and WRITE high together on a hit -> READDATA returned, block unchanged, dirty unchanged; MEM_BUSYWAIT low in the first strobe cycle -> 1-cycle transfer completes correctly.
